jtag_shift_sequencer: RTL and testbench

JTAG_SHIFT_SEQUENCER -- requirements
Module: jtag_shift_sequencer

---
 rtl/jtag_seq_pkg.sv | 66 ++++++
 rtl/ctrlport_req_engine.sv | 93 +++++++++
 rtl/jtag_shift_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_jtag_shift_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_seq_pkg.sv
// rtl/jtag_seq_pkg.sv - shared register map, CONTROL fields, status codes and types for the JTAG sequencer
package jtag_seq_pkg;

  // Register offsets within the JTAG window
  localparam logic [19:0] OFF_TX_DATA  = 20'h00;
  localparam logic [19:0] OFF_STB_DATA = 20'h04;
  localparam logic [19:0] OFF_CONTROL  = 20'h08;
  localparam logic [19:0] OFF_RX_DATA  = 20'h0C;

  // CONTROL register field positions
  localparam int CTRL_PRESCALAR_LSB = 0;
  localparam int CTRL_PRESCALAR_W   = 8;
  localparam int CTRL_LENGTH_LSB    = 8;
  localparam int CTRL_LENGTH_W      = 5;
  localparam int CTRL_RESET_BIT     = 31;
  localparam int CTRL_READY_BIT     = 31;

  // ControlPort response status codes
  typedef enum logic [1:0] {
    STS_OKAY    = 2'd0,
    STS_CMDERR  = 2'd1,
    STS_TSERR   = 2'd2,
    STS_WARNING = 2'd3
  } ctrl_sts_t;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PRE_POLL  = 4'd1,
    ST_WR_TX     = 4'd2,
    ST_WR_STB    = 4'd3,
    ST_WR_CTRL   = 4'd4,
    ST_POST_POLL = 4'd5,
    ST_RD_RX     = 4'd6,
    ST_SOFT_RST  = 4'd7,
    ST_RESP      = 4'd8
  } seq_state_t;

  // One ControlPort access as handed to the request engine
  typedef struct packed {
    logic        wr;
    logic [19:0] addr;
    logic [31:0] data;
  } ctrl_req_t;

  function automatic ctrl_req_t make_req(input logic wr, input logic [19:0] addr,
                                         input logic [31:0] data);
    ctrl_req_t r;
    r.wr   = wr;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

  // Build a CONTROL word; the reset bit and the shift fields are never combined in practice
  function automatic logic [31:0] ctrl_word(input logic [4:0] len, input logic [7:0] presc,
                                            input logic soft_reset);
    logic [31:0] w;
    w = '0;
    w[CTRL_PRESCALAR_LSB +: CTRL_PRESCALAR_W] = presc;
    w[CTRL_LENGTH_LSB +: CTRL_LENGTH_W]       = len;
    w[CTRL_RESET_BIT]                         = soft_reset;
    return w;
  endfunction

endpackage

// File: rtl/ctrlport_req_engine.sv
// rtl/ctrlport_req_engine.sv - issues one ControlPort access and reports ack/status/data or timeout
module ctrlport_req_engine
  import jtag_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  ctrl_req_t   start_req,
  output logic        req_wr,
  output logic        req_rd,
  output logic [19:0] req_addr,
  output logic [31:0] req_data,
  input  logic        resp_ack,
  input  logic [1:0]  resp_status,
  input  logic [31:0] resp_data,
  output logic        done,
  output logic        timeout,
  output logic [1:0]  status,
  output logic [31:0] rdata
);

  localparam int TW = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT);

  logic          busy_q, busy_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          req_wr_q, req_wr_d;
  logic          req_rd_q, req_rd_d;
  logic [19:0]   req_addr_q, req_addr_d;
  logic [31:0]   req_data_q, req_data_d;
  logic          ack_seen;

  assign req_wr   = req_wr_q;
  assign req_rd   = req_rd_q;
  assign req_addr = req_addr_q;
  assign req_data = req_data_q;

  // Completion decode: acks only count while waiting, and an ack on the expiry cycle wins
  always_comb begin
    ack_seen = busy_q && resp_ack;
    timeout  = busy_q && !resp_ack && (tmo_cnt_q >= TMAX);
    done     = ack_seen || timeout;
    status   = resp_status;
    rdata    = resp_data;
  end

  // Next-state: strobes last one cycle, the wait counter restarts on every issue
  always_comb begin
    busy_d     = busy_q;
    tmo_cnt_d  = tmo_cnt_q;
    req_wr_d   = 1'b0;
    req_rd_d   = 1'b0;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    if (busy_q) begin
      if (done) begin
        busy_d = 1'b0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end
    if (start) begin
      busy_d     = 1'b1;
      tmo_cnt_d  = '0;
      req_wr_d   = start_req.wr;
      req_rd_d   = !start_req.wr;
      req_addr_d = start_req.addr;
      req_data_d = start_req.wr ? start_req.data : 32'd0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      tmo_cnt_q  <= '0;
      req_wr_q   <= 1'b0;
      req_rd_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else begin
      busy_q     <= busy_d;
      tmo_cnt_q  <= tmo_cnt_d;
      req_wr_q   <= req_wr_d;
      req_rd_q   <= req_rd_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
    end
  end

endmodule

// File: rtl/jtag_shift_sequencer.sv
// rtl/jtag_shift_sequencer.sv - runs one JTAG shift through the ControlPort register window per command
module jtag_shift_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int JTAG_BASE_ADDRESS = 0,
  parameter int ACK_TIMEOUT       = 255,
  parameter int POLL_LIMIT        = 1023
) (
  input  logic        ctrlport_clk,
  input  logic        ctrlport_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_tdi,
  input  logic [31:0] cmd_tms,
  input  logic [4:0]  cmd_len,
  input  logic [7:0]  cmd_prescalar,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_tdo,
  output logic        resp_error,
  output logic        m_ctrlport_req_wr,
  output logic        m_ctrlport_req_rd,
  output logic [19:0] m_ctrlport_req_addr,
  output logic [31:0] m_ctrlport_req_data,
  input  logic        m_ctrlport_resp_ack,
  input  logic [1:0]  m_ctrlport_resp_status,
  input  logic [31:0] m_ctrlport_resp_data
);

  localparam logic [19:0] ADDR_TX      = 20'(JTAG_BASE_ADDRESS) + OFF_TX_DATA;
  localparam logic [19:0] ADDR_STB     = 20'(JTAG_BASE_ADDRESS) + OFF_STB_DATA;
  localparam logic [19:0] ADDR_CONTROL = 20'(JTAG_BASE_ADDRESS) + OFF_CONTROL;
  localparam logic [19:0] ADDR_RX      = 20'(JTAG_BASE_ADDRESS) + OFF_RX_DATA;

  localparam int PW = ($clog2(POLL_LIMIT + 1) > 0) ? $clog2(POLL_LIMIT + 1) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

  seq_state_t    state_q, state_d;
  logic [31:0]   tdi_q, tdi_d;
  logic [31:0]   tms_q, tms_d;
  logic [4:0]    len_q, len_d;
  logic [7:0]    presc_q, presc_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [31:0]   tdo_q, tdo_d;
  logic          error_q, error_d;

  logic          eng_start;
  ctrl_req_t     eng_req;
  logic          eng_done;
  logic          eng_timeout;
  logic [1:0]    eng_status;
  logic [31:0]   eng_rdata;
  logic          acc_fail;
  logic          go_soft;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_tdo   = tdo_q;
  assign resp_error = error_q;

  ctrlport_req_engine #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_req_engine (
    .clk         (ctrlport_clk),
    .rst_n       (ctrlport_rst_n),
    .start       (eng_start),
    .start_req   (eng_req),
    .req_wr      (m_ctrlport_req_wr),
    .req_rd      (m_ctrlport_req_rd),
    .req_addr    (m_ctrlport_req_addr),
    .req_data    (m_ctrlport_req_data),
    .resp_ack    (m_ctrlport_resp_ack),
    .resp_status (m_ctrlport_resp_status),
    .resp_data   (m_ctrlport_resp_data),
    .done        (eng_done),
    .timeout     (eng_timeout),
    .status      (eng_status),
    .rdata       (eng_rdata)
  );

  // Next-state and request selection; the next access is issued on the same edge the ack is taken
  always_comb begin
    state_d    = state_q;
    tdi_d      = tdi_q;
    tms_d      = tms_q;
    len_d      = len_q;
    presc_d    = presc_q;
    poll_cnt_d = poll_cnt_q;
    tdo_d      = tdo_q;
    error_d    = error_q;
    eng_start  = 1'b0;
    eng_req    = make_req(1'b0, 20'd0, 32'd0);
    go_soft    = 1'b0;
    acc_fail   = eng_timeout || (ctrl_sts_t'(eng_status) != STS_OKAY);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          tdi_d      = cmd_tdi;
          tms_d      = cmd_tms;
          len_d      = cmd_len;
          presc_d    = cmd_prescalar;
          poll_cnt_d = '0;
          eng_start  = 1'b1;
          eng_req    = make_req(1'b0, ADDR_CONTROL, 32'd0);
          state_d    = ST_PRE_POLL;
        end
      end
      ST_PRE_POLL, ST_POST_POLL: begin
        if (eng_done) begin
          if (acc_fail) begin
            go_soft = 1'b1;
          end else if (eng_rdata[CTRL_READY_BIT]) begin
            eng_start = 1'b1;
            if (state_q == ST_PRE_POLL) begin
              eng_req = make_req(1'b1, ADDR_TX, tdi_q);
              state_d = ST_WR_TX;
            end else begin
              eng_req = make_req(1'b0, ADDR_RX, 32'd0);
              state_d = ST_RD_RX;
            end
          end else if (poll_cnt_q == POLL_LAST) begin
            go_soft = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + PW'(1);
            eng_start  = 1'b1;
            eng_req    = make_req(1'b0, ADDR_CONTROL, 32'd0);
          end
        end
      end
      ST_WR_TX: begin
        if (eng_done) begin
          if (acc_fail) begin
            go_soft = 1'b1;
          end else begin
            eng_start = 1'b1;
            eng_req   = make_req(1'b1, ADDR_STB, tms_q);
            state_d   = ST_WR_STB;
          end
        end
      end
      ST_WR_STB: begin
        if (eng_done) begin
          if (acc_fail) begin
            go_soft = 1'b1;
          end else begin
            eng_start = 1'b1;
            eng_req   = make_req(1'b1, ADDR_CONTROL, ctrl_word(len_q, presc_q, 1'b0));
            state_d   = ST_WR_CTRL;
          end
        end
      end
      ST_WR_CTRL: begin
        if (eng_done) begin
          if (acc_fail) begin
            go_soft = 1'b1;
          end else begin
            poll_cnt_d = '0;
            eng_start  = 1'b1;
            eng_req    = make_req(1'b0, ADDR_CONTROL, 32'd0);
            state_d    = ST_POST_POLL;
          end
        end
      end
      ST_RD_RX: begin
        if (eng_done) begin
          if (acc_fail) begin
            go_soft = 1'b1;
          end else begin
            tdo_d   = eng_rdata;
            error_d = 1'b0;
            state_d = ST_RESP;
          end
        end
      end
      ST_SOFT_RST: begin
        // Any completion, good or bad, ends the recovery write
        if (eng_done) begin
          tdo_d   = 32'd0;
          error_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (go_soft) begin
      eng_start = 1'b1;
      eng_req   = make_req(1'b1, ADDR_CONTROL, ctrl_word(5'd0, 8'd0, 1'b1));
      state_d   = ST_SOFT_RST;
    end
  end

  // State and latched command/response registers
  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      state_q    <= ST_IDLE;
      tdi_q      <= '0;
      tms_q      <= '0;
      len_q      <= '0;
      presc_q    <= '0;
      poll_cnt_q <= '0;
      tdo_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tdi_q      <= tdi_d;
      tms_q      <= tms_d;
      len_q      <= len_d;
      presc_q    <= presc_d;
      poll_cnt_q <= poll_cnt_d;
      tdo_q      <= tdo_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
// tb/tb_jtag_shift_sequencer.sv - directed self-checking bench for jtag_shift_sequencer
module tb_jtag_shift_sequencer;

  localparam int          BASE   = 'h1000;
  localparam logic [19:0] A_TX   = 20'h01000;
  localparam logic [19:0] A_STB  = 20'h01004;
  localparam logic [19:0] A_CTRL = 20'h01008;
  localparam logic [19:0] A_RX   = 20'h0100C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_tdi = '0;
  logic [31:0] cmd_tms = '0;
  logic [4:0]  cmd_len = '0;
  logic [7:0]  cmd_prescalar = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_tdo;
  logic        resp_error;
  logic        req_wr;
  logic        req_rd;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic        ack = 1'b0;
  logic [1:0]  sts = 2'd0;
  logic [31:0] rdat = '0;

  // Slave configuration, driven only by the stimulus block
  logic        sl_err_tx = 1'b0;
  logic        sl_never_ack = 1'b0;
  logic        sl_never_ready = 1'b0;
  int          sl_notready = 0;
  logic [31:0] sl_rx = '0;
  logic        log_clr = 1'b0;

  // Slave state and access log, driven only by the slave model
  logic        shifting = 1'b0;
  int          nr_left = 0;
  int          log_n = 0;
  logic        log_wr[64];
  logic [19:0] log_addr[64];
  logic [31:0] log_data[64];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jtag_shift_sequencer #(
    .JTAG_BASE_ADDRESS (BASE),
    .ACK_TIMEOUT       (16),
    .POLL_LIMIT        (8)
  ) dut (
    .ctrlport_clk           (clk),
    .ctrlport_rst_n         (rst_n),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_tdi                (cmd_tdi),
    .cmd_tms                (cmd_tms),
    .cmd_len                (cmd_len),
    .cmd_prescalar          (cmd_prescalar),
    .resp_valid             (resp_valid),
    .resp_ready             (resp_ready),
    .resp_tdo               (resp_tdo),
    .resp_error             (resp_error),
    .m_ctrlport_req_wr      (req_wr),
    .m_ctrlport_req_rd      (req_rd),
    .m_ctrlport_req_addr    (req_addr),
    .m_ctrlport_req_data    (req_data),
    .m_ctrlport_resp_ack    (ack),
    .m_ctrlport_resp_status (sts),
    .m_ctrlport_resp_data   (rdat)
  );

  // ControlPort slave: logs every strobe, answers one cycle later
  always @(posedge clk) begin
    ack  <= 1'b0;
    sts  <= 2'd0;
    rdat <= '0;
    if (req_wr || req_rd) begin
      if (log_n < 64) begin
        log_wr[log_n]   <= req_wr;
        log_addr[log_n] <= req_addr;
        log_data[log_n] <= req_data;
      end
      log_n <= log_n + 1;
    end
    if (!rst_n) begin
      shifting <= 1'b0;
      nr_left  <= 0;
    end else if ((req_wr || req_rd) && !sl_never_ack) begin
      ack <= 1'b1;
      if (req_wr && req_addr == A_CTRL && !req_data[31]) begin
        shifting <= 1'b1;
        nr_left  <= sl_notready;
      end
      if (req_wr && req_addr == A_TX && sl_err_tx) sts <= 2'd1;
      if (req_rd && req_addr == A_CTRL) begin
        if (sl_never_ready) rdat <= 32'h0;
        else if (shifting && nr_left > 0) begin
          rdat    <= 32'h0;
          nr_left <= nr_left - 1;
        end else rdat <= 32'h8000_0000;
      end
      if (req_rd && req_addr == A_RX) begin
        rdat     <= sl_rx;
        shifting <= 1'b0;
      end
    end
    if (log_clr) log_n <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    @(posedge clk); #1;
    log_clr = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] tdi, input logic [31:0] tms,
                          input logic [4:0] len, input logic [7:0] ps);
    int w;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_tdi = tdi;
    cmd_tms = tms;
    cmd_len = len;
    cmd_prescalar = ps;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int w;
    int nrd;
    logic stable;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_resp_tdo", resp_tdo, 32'd0);
    check("rst_req_wr", {31'd0, req_wr}, 32'd0);
    check("rst_req_rd", {31'd0, req_rd}, 32'd0);
    check("rst_req_addr", {12'd0, req_addr}, 32'd0);
    check("rst_req_data", req_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // Basic transaction, minimum latency
    sl_rx = 32'h5A5A_5A5A;
    clear_log();
    send_cmd(32'hA5A5_A5A5, 32'h1, 5'd31, 8'd3);
    wait_resp(lat);
    check("t1_latency", lat, 32'd12);
    check("t1_tdo", resp_tdo, 32'h5A5A_5A5A);
    check("t1_error", {31'd0, resp_error}, 32'd0);
    check("t1_access_count", log_n, 32'd6);
    check("t1_tx_addr", {12'd0, log_addr[1]}, {12'd0, A_TX});
    check("t1_tx_data", log_data[1], 32'hA5A5_A5A5);
    check("t1_stb_addr", {12'd0, log_addr[2]}, {12'd0, A_STB});
    check("t1_stb_data", log_data[2], 32'h0000_0001);
    check("t1_ctrl_addr", {12'd0, log_addr[3]}, {12'd0, A_CTRL});
    check("t1_ctrl_data", log_data[3], 32'h0000_1F03);
    check("t1_rx_addr", {12'd0, log_addr[5]}, {12'd0, A_RX});

    // Response held while resp_ready stays low
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_tdo !== 32'h5A5A_5A5A || cmd_ready) stable = 1'b0;
    end
    check("hold_stable", {31'd0, stable}, 32'd1);
    ack_resp();
    check("hold_released_valid", {31'd0, resp_valid}, 32'd0);
    check("hold_released_ready", {31'd0, cmd_ready}, 32'd1);

    // Five not-ready post-shift polls
    sl_notready = 5;
    sl_rx = 32'hCAFE_F00D;
    clear_log();
    send_cmd(32'h1234_5678, 32'h3, 5'd7, 8'd0);
    wait_resp(lat);
    check("t2_latency", lat, 32'd22);
    check("t2_access_count", log_n, 32'd11);
    nrd = 0;
    for (int i = 4; i < 10; i++) if (!log_wr[i] && log_addr[i] == A_CTRL) nrd++;
    check("t2_post_polls", nrd, 32'd6);
    check("t2_rx_addr", {12'd0, log_addr[10]}, {12'd0, A_RX});
    check("t2_ctrl_data", log_data[3], 32'h0000_0700);
    check("t2_tdo", resp_tdo, 32'hCAFE_F00D);
    ack_resp();
    sl_notready = 0;

    // TX write answered with CMDERR
    sl_err_tx = 1'b1;
    clear_log();
    send_cmd(32'hDEAD_BEEF, 32'h0, 5'd3, 8'd1);
    wait_resp(lat);
    check("t3_latency", lat, 32'd6);
    check("t3_access_count", log_n, 32'd3);
    check("t3_soft_wr", {31'd0, log_wr[2]}, 32'd1);
    check("t3_soft_addr", {12'd0, log_addr[2]}, {12'd0, A_CTRL});
    check("t3_soft_data", log_data[2], 32'h8000_0000);
    check("t3_error", {31'd0, resp_error}, 32'd1);
    check("t3_tdo", resp_tdo, 32'd0);
    ack_resp();
    sl_err_tx = 1'b0;

    // Slave never acks: 16-cycle timeout on each access
    sl_never_ack = 1'b1;
    clear_log();
    send_cmd(32'h1, 32'h1, 5'd0, 8'd0);
    w = 0;
    while (!req_wr && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("t4_timeout_cycle", w, 32'd17);
    check("t4_soft_addr", {12'd0, req_addr}, {12'd0, A_CTRL});
    check("t4_soft_data", req_data, 32'h8000_0000);
    wait_resp(lat);
    check("t4_soft_latency", lat, 32'd17);
    check("t4_error", {31'd0, resp_error}, 32'd1);
    ack_resp();
    sl_never_ack = 1'b0;

    // Ready never set: poll limit of 8 reads
    sl_never_ready = 1'b1;
    clear_log();
    send_cmd(32'h2, 32'h2, 5'd1, 8'd2);
    wait_resp(lat);
    check("t5_latency", lat, 32'd18);
    check("t5_access_count", log_n, 32'd9);
    check("t5_last_poll_rd", {31'd0, log_wr[7]}, 32'd0);
    check("t5_soft_data", log_data[8], 32'h8000_0000);
    check("t5_error", {31'd0, resp_error}, 32'd1);
    ack_resp();
    sl_never_ready = 1'b0;

    // Reset during WR_STB, then a clean transaction
    sl_rx = 32'h5A5A_5A5A;
    clear_log();
    send_cmd(32'hA5A5_A5A5, 32'h1, 5'd31, 8'd3);
    w = 0;
    while (!(req_wr && req_addr == A_STB) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("t6_stb_cycle", w, 32'd4);
    rst_n = 1'b0;
    #1;
    check("t6_req_wr", {31'd0, req_wr}, 32'd0);
    check("t6_req_addr", {12'd0, req_addr}, 32'd0);
    check("t6_req_data", req_data, 32'd0);
    check("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t6_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("t6_no_strobe", log_n, 32'd2);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
    send_cmd(32'hA5A5_A5A5, 32'h1, 5'd31, 8'd3);
    wait_resp(lat);
    check("t6_latency", lat, 32'd12);
    check("t6_tdo", resp_tdo, 32'h5A5A_5A5A);
    check("t6_error", {31'd0, resp_error}, 32'd0);
    check("t6_access_count", log_n, 32'd6);
    ack_resp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
